fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the CPU execute state machine. It drives the instruction-memory port, prefetches instruction words into a small queue, and hands them to execute over a valid/ready handshake, tagged with their PC. Unconditional jumps are resolved in this stage at fetch time. Fetching stops permanently after a halt, until the next reset.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 33 +++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU constants, opcode values and fetch state encoding
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int JT_MSB = 11;
  localparam int JT_LSB = 0;
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_HLT = 4'h3;
  localparam logic [3:0] OP_LD = 4'h4;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} fetch_state_e;
  function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
  function automatic logic [ADDR_W-1:0] jump_target(input logic [INSTR_W-1:0] instr);
    return ADDR_W'(instr[JT_MSB:JT_LSB]);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: queue of {pc, instr} words with occupancy count and simultaneous push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // storage needs no reset: the head is forced to zero while empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  assign rdata = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with jump/halt resolution and prefetch queue
module fetch_unit import cpu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state;
  logic [ADDR_W-1:0] fetch_pc, next_pc;
  logic [CW-1:0] count, count_next;
  logic ack, pop, room;
  logic [ADDR_W+INSTR_W-1:0] head;
  assign ack = (state == S_WAIT) && imem_ack;
  assign pop = out_valid && out_ready;
  assign count_next = count + CW'(ack) - CW'(pop);
  assign room = count_next < CW'(DEPTH);
  assign next_pc = (opcode(imem_rdata) == OP_JMP) ? jump_target(imem_rdata) : imem_addr + 16'd1;
  assign out_valid = count != '0;
  assign {out_pc, out_instr} = head;
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + INSTR_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(ack),
    .pop(pop),
    .wdata({imem_addr, imem_rdata}),
    .rdata(head),
    .count(count)
  );
  // fetch FSM: issue only when the post-edge occupancy leaves a slot, re-issue on ack to sustain 1/cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_RUN;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      halted <= 1'b0;
    end else begin
      case (state)
        S_RUN:
          if (room) begin
            state <= S_WAIT;
            imem_req <= 1'b1;
            imem_addr <= fetch_pc;
          end
        S_WAIT:
          if (imem_ack) begin
            if (opcode(imem_rdata) == OP_HLT) begin
              state <= S_HALTED;
              imem_req <= 1'b0;
              halted <= 1'b1;
            end else begin
              fetch_pc <= next_pc;
              if (room) imem_addr <= next_pc;
              else begin
                state <= S_RUN;
                imem_req <= 1'b0;
              end
            end
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: program-order reference model, directed corner sequences and randomized runs
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [15:0] RPC = 16'hFFFF;
  logic clk = 0, rst_n = 1;
  logic imem_req, imem_ack, out_valid, out_ready, halted;
  logic [15:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic [15:0] mem [0:65535];
  bit used [0:65535];
  int total = 0, bad = 0, acks = 0, pops = 0, cyc = 0, wcnt = 0, rlat = 0;
  int fix_lat = 0, maxlat = 0, ready_pct = 100;
  bit mute = 0, stray = 0, rnd_lat = 0, rnd_ready = 0, man_ready = 0, rnd_rdy = 0;
  logic [31:0] exp_q [$];
  logic [15:0] ack_log [$];
  int ack_cyc [$], pop_cyc [$];
  logic prev_req = 0, prev_ack = 0, prev_hlt = 0;
  logic [15:0] prev_addr = 0;
  logic [15:0] a_exp [6] = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0005, 16'h0006, 16'h0007};
  typedef struct {int len; int maxlat; int ready_pct; int exp_pops; bit exp_halted;} vec_t;
  vec_t vt [4] = '{'{12, 0, 100, 12, 1}, '{20, 2, 60, 20, 1}, '{30, 3, 30, 30, 1}, '{25, 1, 80, 25, 1}};

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];
  assign imem_ack = stray || (!mute && imem_req && wcnt >= (rnd_lat ? rlat : fix_lat));
  assign out_ready = rnd_ready ? rnd_rdy : man_ready;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || (imem_req && imem_ack)) wcnt <= 0;
    else if (imem_req) wcnt <= wcnt + 1;
    if (imem_req && imem_ack) rlat <= $urandom_range(0, maxlat);
  end

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 99) < ready_pct);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      acks = 0; pops = 0;
      ack_log.delete(); ack_cyc.delete(); pop_cyc.delete();
      prev_req = 0; prev_ack = 0; prev_hlt = 0;
    end else begin
      if (prev_req && !prev_ack && imem_req) check("addr_stable", imem_addr, prev_addr);
      if (prev_hlt) begin
        check("halt_flag", halted, 1);
        check("halt_req", imem_req, 0);
      end
      if (halted) check("no_req_halted", imem_req, 0);
      check("space", (acks - pops + int'(imem_req)) <= DEPTH, 1);
      check("valid", out_valid, acks > pops);
      if (out_valid && out_ready) begin
        if (pops < exp_q.size()) check("deliver", {out_pc, out_instr}, exp_q[pops]);
        else begin
          total++; bad++;
          $display("FAIL extra_deliver: got %h expected none", {out_pc, out_instr});
        end
        pop_cyc.push_back(cyc);
        pops++;
      end
      prev_hlt = imem_req && imem_ack && imem_rdata[15:12] == 4'h3;
      if (imem_req && imem_ack) begin
        ack_log.push_back(imem_addr);
        ack_cyc.push_back(cyc);
        acks++;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0;
      used[i] = 0;
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] w);
    mem[a] = w;
    used[a] = 1;
  endtask

  task automatic build_exp();
    logic [15:0] pc, w;
    exp_q.delete();
    pc = RPC;
    for (int k = 0; k < 1000; k++) begin
      w = mem[pc];
      exp_q.push_back({pc, w});
      if (w[15:12] == 4'h3) break;
      pc = (w[15:12] == 4'h2) ? {4'h0, w[11:0]} : pc + 16'd1;
    end
  endtask

  task automatic gen(input int len);
    logic [15:0] pc, nxt, t;
    logic [3:0] op;
    clear_mem();
    pc = RPC;
    for (int k = 0; k < len; k++) begin
      used[pc] = 1;
      nxt = pc + 16'd1;
      if (k == len - 1) mem[pc] = {4'h3, 12'($urandom)};
      else if ($urandom_range(0, 5) == 0 || used[nxt]) begin
        do t = 16'($urandom_range(0, 4095)); while (used[t]);
        mem[pc] = {4'h2, t[11:0]};
        nxt = t;
      end else begin
        do op = 4'($urandom_range(0, 15)); while (op == 4'h2 || op == 4'h3);
        mem[pc] = {op, 12'($urandom)};
      end
      pc = nxt;
    end
  endtask

  task automatic start();
    rst_n = 0;
    build_exp();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((pops != exp_q.size() || !halted) && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_instr"}, out_instr, 0);
    check({tag, "_pc"}, out_pc, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    clear_mem();
    #2 rst_n = 0;
    #1 check_reset("por");
    // sequential fetch through a wrap, a jump and a halt
    put(16'hFFFF, 16'h0ABC); put(16'h0000, 16'h0121); put(16'h0001, 16'h2005);
    put(16'h0005, 16'h1123); put(16'h0006, 16'h4052); put(16'h0007, 16'h3000);
    man_ready = 1;
    start();
    check("a_first_req0", imem_req, 0);
    tick();
    check("a_first_req", imem_req, 1);
    check("a_first_addr", imem_addr, RPC);
    wait_done("a_done", 100);
    check("a_ack_n", ack_log.size(), 6);
    if (ack_log.size() == 6 && pop_cyc.size() == 6)
      for (int i = 0; i < 6; i++) begin
        check("a_addr", ack_log[i], a_exp[i]);
        check("a_req_gap", ack_cyc[i] - ack_cyc[0], i);
        check("a_pop_gap", pop_cyc[i] - pop_cyc[0], i);
      end
    repeat (10) tick();
    check("a_idle_req", imem_req, 0);
    check("a_idle_acks", acks, 6);
    check("a_idle_valid", out_valid, 0);
    // backpressure: queue fills to DEPTH, one pop admits exactly one fetch
    clear_mem();
    put(16'hFFFF, 16'h4000);
    for (int i = 0; i < 10; i++) put(16'(i), {4'h1, 12'(i)});
    put(16'h000A, 16'h3000);
    man_ready = 0;
    start();
    repeat (12) tick();
    check("b_acks4", acks, 4);
    check("b_req_low", imem_req, 0);
    check("b_valid", out_valid, 1);
    man_ready = 1;
    tick();
    man_ready = 0;
    repeat (6) tick();
    check("b_acks5", acks, 5);
    check("b_pops1", pops, 1);
    check("b_req_low2", imem_req, 0);
    man_ready = 1;
    wait_done("b_done", 200);
    // reset while a request is outstanding, then a stray ack right after release
    clear_mem();
    put(16'hFFFF, 16'h0111);
    for (int i = 0; i < 6; i++) put(16'(i), {4'h5, 12'(i + 16)});
    put(16'h0006, 16'h3ABC);
    man_ready = 0;
    start();
    repeat (3) tick();
    mute = 1;
    tick();
    tick();
    check("c_req_held", imem_req, 1);
    check("c_valid_pre", out_valid, 1);
    rst_n = 0;
    #1 check_reset("c_rst");
    tick();
    tick();
    mute = 0;
    rst_n = 1;
    stray = 1;
    tick();
    stray = 0;
    check("c_restart_req", imem_req, 1);
    check("c_restart_addr", imem_addr, RPC);
    man_ready = 1;
    wait_done("c_done", 200);
    check("c_pops", pops, 8);
    // slow memory: ack three cycles after each request
    clear_mem();
    put(16'hFFFF, 16'h1001); put(16'h0000, 16'h2010); put(16'h0010, 16'h4ABC); put(16'h0011, 16'h3FFF);
    fix_lat = 3;
    start();
    wait_done("d_done", 200);
    check("d_ack_n", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check("d_jump_addr", ack_log[2], 16'h0010);
      for (int i = 1; i < 4; i++) check("d_ack_gap", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    fix_lat = 0;
    // randomized programs, latencies and backpressure
    for (int v = 0; v < 4; v++) begin
      gen(vt[v].len);
      maxlat = vt[v].maxlat;
      ready_pct = vt[v].ready_pct;
      rnd_lat = 1;
      rnd_ready = 1;
      start();
      wait_done("e_done", 3000);
      check("e_pops", pops, vt[v].exp_pops);
      check("e_acks", acks, vt[v].len);
      check("e_halted", halted, vt[v].exp_halted);
      repeat (5) tick();
      check("e_idle_req", imem_req, 0);
      rnd_ready = 0;
      rnd_lat = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
